// File: rtl/debounce_array.sv
// N-channel switch conditioner. Each channel has a 2-flop synchroniser, a debounce
// counter, registered press/release pulses and an optional long-press (hold) pulse.
module debounce_lane #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);
  localparam int             CW      = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Only sync2 is trusted; any disagreement with the accepted level must persist
  // for DEBOUNCE_LIMIT consecutive cycles before the level flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
          rel   <= ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  generate
    if (HOLD_LIMIT > 0) begin : g_hold
      localparam int            HW       = $clog2(HOLD_LIMIT + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT - 1);

      logic [HW-1:0] hcnt;
      logic          done;

      // Counter freezes at HOLD_LIMIT once done, so only one pulse per press.
      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt <= '0;
          done <= 1'b0;
          hold <= 1'b0;
        end else begin
          hold <= 1'b0;
          if (!level) begin
            hcnt <= '0;
            done <= 1'b0;
          end else if (!done) begin
            hcnt <= hcnt + HW'(1);
            if (hcnt == HOLD_MAX) begin
              hold <= 1'b1;
              done <= 1'b1;
            end
          end
        end
      end
    end else begin : g_no_hold
      assign hold = 1'b0;
    end
  endgenerate
endmodule

module debounce_array #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switches,
  output logic [NUM_CH-1:0] o_Switches,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Hold,
  output logic              o_Any_Press
);
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      debounce_lane #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
        .HOLD_LIMIT    (HOLD_LIMIT)
      ) u_lane (
        .clk  (i_Clk),
        .rst  (i_Reset),
        .sw   (i_Switches[i]),
        .level(o_Switches[i]),
        .press(o_Press[i]),
        .rel  (o_Release[i]),
        .hold (o_Hold[i])
      );
    end
  endgenerate

  assign o_Any_Press = |o_Press;
endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10.
module tb_debounce_array;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] level, press, rel, hold;
  logic       any_press;

  int checks = 0;
  int errors = 0;
  int press_cnt [4];
  int rel_cnt   [4];
  int hold_cnt  [4];
  int both_cnt = 0;
  int p_snap, r_snap, h_snap;

  debounce_array #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(10)) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Switches (sw),
    .o_Switches (level),
    .o_Press    (press),
    .o_Release  (rel),
    .o_Hold     (hold),
    .o_Any_Press(any_press)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled away from the active edge.
  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; hold_cnt[i] = 0;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] <= press_cnt[i] + int'(press[i]);
      rel_cnt[i]   <= rel_cnt[i] + int'(rel[i]);
      hold_cnt[i]  <= hold_cnt[i] + int'(hold[i]);
    end
    if ((press & rel) != 4'b0) both_cnt <= both_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 4'b0000;
    step(2);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_rel",   32'(rel),   32'h0);
    chk("rst_hold",  32'(hold),  32'h0);
    chk("rst_any",   32'(any_press), 32'h0);

    // Clean press on channel 0: accepted after edge k+5.
    rst = 1'b0;
    sw  = 4'b0001;
    step(5);
    chk("press0_early", 32'(level), 32'h0);
    chk("press0_pulse_cyc", 32'(press), 32'h0);
    step(1);
    chk("press0_level", 32'(level), 32'h1);
    chk("press0_press", 32'(press), 32'h1);
    chk("press0_any",   32'(any_press), 32'h1);
    chk("press0_rel",   32'(rel), 32'h0);
    step(1);
    chk("press0_pulse_end", 32'(press), 32'h0);
    chk("press0_any_end",   32'(any_press), 32'h0);
    chk("press0_held",      32'(level), 32'h1);

    // Bounce on channel 1: 3 high, 1 low, 3 high, low -> rejected.
    p_snap = press_cnt[1];
    r_snap = rel_cnt[1];
    sw[1] = 1'b1; step(3);
    sw[1] = 1'b0; step(1);
    sw[1] = 1'b1; step(3);
    sw[1] = 1'b0; step(10);
    chk("bounce_level", 32'(level[1]), 32'h0);
    chk("bounce_no_press", 32'(press_cnt[1]), 32'(p_snap));
    chk("bounce_no_rel",   32'(rel_cnt[1]),   32'(r_snap));
    // Exactly DEBOUNCE_LIMIT cycles high is accepted once.
    sw[1] = 1'b1; step(4);
    sw[1] = 1'b0; step(12);
    chk("bounce4_press", 32'(press_cnt[1]), 32'(p_snap + 1));
    chk("bounce4_rel",   32'(rel_cnt[1]),   32'(r_snap + 1));

    // Release on channel 2.
    sw[2] = 1'b1;
    step(8);
    chk("rel2_up", 32'(level[2]), 32'h1);
    sw[2] = 1'b0;
    step(5);
    chk("rel2_early", 32'(level[2]), 32'h1);
    step(1);
    chk("rel2_level", 32'(level[2]), 32'h0);
    chk("rel2_pulse", 32'(rel), 32'h4);
    chk("rel2_no_press", 32'(press), 32'h0);
    step(1);
    chk("rel2_pulse_end", 32'(rel), 32'h0);

    // Hold on channel 3: single pulse exactly 10 cycles after the press cycle.
    sw[3] = 1'b1;
    step(6);
    chk("hold3_press", 32'(press), 32'h8);
    h_snap = hold_cnt[3];
    step(9);
    chk("hold3_early", 32'(hold[3]), 32'h0);
    step(1);
    chk("hold3_pulse", 32'(hold), 32'h8);
    step(1);
    chk("hold3_pulse_end", 32'(hold[3]), 32'h0);
    step(20);
    chk("hold3_once", 32'(hold_cnt[3]), 32'(h_snap + 1));
    sw[3] = 1'b0;
    step(10);

    // Release debounced 8 cycles after press -> no hold.
    sw[3] = 1'b1;
    step(6);
    chk("nohold_press", 32'(press[3]), 32'h1);
    step(2);
    sw[3] = 1'b0;
    h_snap = hold_cnt[3];
    step(5);
    chk("nohold_still_up", 32'(level[3]), 32'h1);
    step(1);
    chk("nohold_rel", 32'(rel[3]), 32'h1);
    chk("nohold_level", 32'(level[3]), 32'h0);
    step(10);
    chk("nohold_none", 32'(hold_cnt[3]), 32'(h_snap));

    // Simultaneous press on channels 0 and 2.
    sw = 4'b0000;
    step(10);
    chk("all_low", 32'(level), 32'h0);
    sw = 4'b0101;
    step(6);
    chk("simul_press", 32'(press), 32'h5);
    chk("simul_any",   32'(any_press), 32'h1);

    // Reset with cnt=2: outputs clear, then re-press 6 edges after deassertion.
    sw = 4'b0000;
    step(10);
    sw = 4'b0101;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_press", 32'(press), 32'h0);
    chk("midrst_rel",   32'(rel),   32'h0);
    chk("midrst_hold",  32'(hold),  32'h0);
    chk("midrst_any",   32'(any_press), 32'h0);
    rst = 1'b0;
    step(5);
    chk("repress_early", 32'(level), 32'h0);
    step(1);
    chk("repress_press", 32'(press), 32'h5);
    chk("repress_level", 32'(level), 32'h5);

    step(2);
    chk("never_press_and_rel", 32'(both_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
Parametrised N-channel switch conditioner for raw, asynchronous, bouncy board inputs. It extends a fixed four-switch debouncer in three ways:
- metastability synchronisation on every input;
- per-channel press/release edge pulses;
- optional long-press (hold) detection.
It sits directly behind the board pins and feeds user-logic state machines, for example the 7-segment counter and the LED toggles.

Parameters:
NUM_CH, 4, number of independent switch channels (>=1).
DEBOUNCE_LIMIT, 250000, consecutive stable cycles needed to accept a new level (10 ms at 25 MHz); >=1.
HOLD_LIMIT, 25000000, cycles the debounced level must stay high before o_Hold pulses (1 s at 25 MHz); 0 disables hold detection.

Ports:
i_Clk  in  1  system clock; all state is updated on the rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Switches  in  NUM_CH  raw switch levels, asynchronous, active-high.
o_Switches  out  NUM_CH  debounced level per channel.
o_Press  out  NUM_CH  1-cycle pulse when the debounced level goes 0->1.
o_Release  out  NUM_CH  1-cycle pulse when the debounced level goes 1->0.
o_Hold  out  NUM_CH  1-cycle pulse after the level has been high for HOLD_LIMIT cycles.
o_Any_Press  out  1  OR of o_Press, same cycle.

Behaviour:
- Reset (i_Reset high at a rising edge) clears all of the following:
  - synchroniser flops;
  - debounce counters and debounced state;
  - hold counters and hold-done flags;
  - all outputs, which read 0 from the next cycle.
- Reset mid-debounce discards the partial count. A switch held high through reset re-debounces from 0 and produces an o_Press once it is accepted.
- Synchroniser: 2 flops per channel (sync1, sync2). Only sync2 feeds the debounce logic.
- Per-channel debounce counter:
  - width clog2(DEBOUNCE_LIMIT+1);
  - mismatch = (sync2 != state).
- Each cycle, per channel:
  - mismatch and cnt < DEBOUNCE_LIMIT-1: cnt <= cnt+1.
  - mismatch and cnt == DEBOUNCE_LIMIT-1: state <= sync2, cnt <= 0.
  - no mismatch: cnt <= 0, so any bounce back restarts the count.
- Latency: a clean input transition set up before edge k appears on o_Switches after edge k+1+DEBOUNCE_LIMIT, i.e. DEBOUNCE_LIMIT+2 edges.
- A glitch shorter than DEBOUNCE_LIMIT cycles at sync2 never changes o_Switches.
- o_Switches is the registered state.
- o_Press and o_Release are registered and high for exactly the cycle in which o_Switches first shows the new value. They are never both high on the same channel.
- Hold logic (HOLD_LIMIT>0), per channel, with a hold counter (width clog2(HOLD_LIMIT+1)) and a done flag:
  - while state==0: counter <= 0 and done <= 0;
  - while state==1 and !done: counter increments;
  - o_Hold pulses in the cycle that is HOLD_LIMIT cycles after the o_Press cycle, then done <= 1;
  - only one o_Hold per press; after that the counter saturates and holds;
  - a release before HOLD_LIMIT produces no o_Hold.
- HOLD_LIMIT==0: o_Hold is constant 0 and no hold counters are generated.
- Channels are fully independent. Simultaneous events on several channels each pulse their own bit in the same cycle, and o_Any_Press ORs them.
- No counter wraps:
  - the debounce counter never exceeds DEBOUNCE_LIMIT-1;
  - the hold counter saturates at HOLD_LIMIT.

Test Plan:
- Setup: NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10.
- Clean press: after reset, set i_Switches=4'b0001 before edge k -> o_Switches[0] goes to 1 after edge k+5; o_Press=4'b0001 and o_Any_Press=1 for exactly that 1 cycle; o_Release=0.
- Bounce rejection: toggle i_Switches[1] high 3 cycles, low 1, high 3, then low -> o_Switches[1] stays 0 and no pulses occur. Holding it high for 4 or more cycles -> o_Press[1] fires once.
- Release: from a debounced-high channel 2, drop the input -> o_Switches[2] goes to 0 six edges later, o_Release[2] pulses for 1 cycle, and no o_Press occurs.
- Hold:
  - hold channel 3 high for 30 cycles -> a single o_Hold[3] pulse exactly 10 cycles after the o_Press[3] cycle;
  - release at 8 cycles after o_Press[3] -> no o_Hold.
- Simultaneous and reset: press channels 0 and 2 on the same cycle -> o_Press=4'b0101 in one cycle. Assert i_Reset for 1 cycle mid-count (cnt=2) -> the next cycle shows all outputs 0, and the still-high inputs re-press DEBOUNCE_LIMIT+2 edges after reset deassertion.
